// File: rtl/multicycle_control_fsm_if.sv
// ============================================================================
// multicycle_control_fsm_if : opcode in / control word out bundle between the
// multi-cycle MIPS control sequencer and its datapath.  Rev 1.0
// ============================================================================
`default_nettype none

interface multicycle_control_fsm_if;
  logic [5:0] opcode;
  logic       pcwrite;
  logic       pcwritecond;
  logic       iord;
  logic       memread;
  logic       memwrite;
  logic       irwrite;
  logic       memtoreg;
  logic       regdst;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] aluop;
  logic [1:0] pcsource;
  logic       instrdone;
  logic       illegalop;
  logic [3:0] state;

  // Controller side: samples the opcode, drives the datapath controls.
  modport master (
    input  opcode,
    output pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
           memtoreg, regdst, regwrite, alusrca, alusrcb, aluop,
           pcsource, instrdone, illegalop, state
  );

  // Datapath side: presents IR[31:26], consumes the controls.
  modport slave (
    output opcode,
    input  pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
           memtoreg, regdst, regwrite, alusrca, alusrcb, aluop,
           pcsource, instrdone, illegalop, state
  );
endinterface

`default_nettype wire

// File: rtl/multicycle_control_fsm.sv
// ============================================================================
// multicycle_control_fsm : Moore control sequencer for the multi-cycle MIPS
// datapath (fetch/decode/execute/memory/writeback).  Rev 1.0
// ============================================================================
`default_nettype none

module multicycle_control_fsm #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010,
  parameter logic [5:0] OP_ADDI  = 6'b001000
) (
  input  logic                      clk,
  input  logic                      reset,
  multicycle_control_fsm_if.master  bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       r_is_lw;
  logic       w_illegal;

  logic       w_pcwrite;
  logic       w_pcwritecond;
  logic       w_iord;
  logic       w_memread;
  logic       w_memwrite;
  logic       w_irwrite;
  logic       w_memtoreg;
  logic       w_regdst;
  logic       w_regwrite;
  logic       w_alusrca;
  logic [1:0] w_alusrcb;
  logic [1:0] w_aluop;
  logic [1:0] w_pcsource;
  logic       w_instrdone;

  // The lw/sw choice is made in DECODE and remembered, since opcode is only
  // meaningful in that state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_is_lw <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_is_lw <= (bus.opcode == OP_LW);
      end
    end
  end

  always_comb begin
    w_next    = S_FETCH;
    w_illegal = 1'b0;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXEC;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          OP_ADDI:      w_next = S_ADDIEX;
          default: begin
            w_next    = S_FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: w_next = r_is_lw ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = S_MEMWB;
      S_EXEC:   w_next = S_ALUWB;
      S_ADDIEX: w_next = S_ADDIWB;
      default:  w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_pcwrite     = 1'b0;
    w_pcwritecond = 1'b0;
    w_iord        = 1'b0;
    w_memread     = 1'b0;
    w_memwrite    = 1'b0;
    w_irwrite     = 1'b0;
    w_memtoreg    = 1'b0;
    w_regdst      = 1'b0;
    w_regwrite    = 1'b0;
    w_alusrca     = 1'b0;
    w_alusrcb     = 2'b00;
    w_aluop       = 2'b00;
    w_pcsource    = 2'b00;
    w_instrdone   = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_memread = 1'b1;
        w_irwrite = 1'b1;
        w_pcwrite = 1'b1;
        w_alusrcb = 2'b01;
      end
      S_DECODE: w_alusrcb = 2'b11;
      S_MEMADR: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
      end
      S_MEMRD: begin
        w_memread = 1'b1;
        w_iord    = 1'b1;
      end
      S_MEMWB: begin
        w_regwrite  = 1'b1;
        w_memtoreg  = 1'b1;
        w_instrdone = 1'b1;
      end
      S_MEMWR: begin
        w_memwrite  = 1'b1;
        w_iord      = 1'b1;
        w_instrdone = 1'b1;
      end
      S_EXEC: begin
        w_alusrca = 1'b1;
        w_aluop   = 2'b10;
      end
      S_ALUWB: begin
        w_regwrite  = 1'b1;
        w_regdst    = 1'b1;
        w_instrdone = 1'b1;
      end
      S_BRANCH: begin
        w_alusrca     = 1'b1;
        w_aluop       = 2'b01;
        w_pcwritecond = 1'b1;
        w_pcsource    = 2'b01;
        w_instrdone   = 1'b1;
      end
      S_JUMP: begin
        w_pcwrite   = 1'b1;
        w_pcsource  = 2'b10;
        w_instrdone = 1'b1;
      end
      S_ADDIEX: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
      end
      S_ADDIWB: begin
        w_regwrite  = 1'b1;
        w_instrdone = 1'b1;
      end
      default: ;
    endcase

    // Reset overrides the state decode immediately, so an instruction caught
    // mid-flight issues no write even before the state register clears.
    if (reset) begin
      w_pcwrite     = 1'b0;
      w_pcwritecond = 1'b0;
      w_iord        = 1'b0;
      w_memread     = 1'b1;
      w_memwrite    = 1'b0;
      w_irwrite     = 1'b0;
      w_memtoreg    = 1'b0;
      w_regdst      = 1'b0;
      w_regwrite    = 1'b0;
      w_alusrca     = 1'b0;
      w_alusrcb     = 2'b01;
      w_aluop       = 2'b00;
      w_pcsource    = 2'b00;
      w_instrdone   = 1'b0;
    end
  end

  assign bus.pcwrite     = w_pcwrite;
  assign bus.pcwritecond = w_pcwritecond;
  assign bus.iord        = w_iord;
  assign bus.memread     = w_memread;
  assign bus.memwrite    = w_memwrite;
  assign bus.irwrite     = w_irwrite;
  assign bus.memtoreg    = w_memtoreg;
  assign bus.regdst      = w_regdst;
  assign bus.regwrite    = w_regwrite;
  assign bus.alusrca     = w_alusrca;
  assign bus.alusrcb     = w_alusrcb;
  assign bus.aluop       = w_aluop;
  assign bus.pcsource    = w_pcsource;
  assign bus.instrdone   = w_instrdone;
  assign bus.illegalop   = w_illegal & ~reset;
  assign bus.state       = r_state;

endmodule

`default_nettype wire
